// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared control-bundle types and encodings for the ID/EX stage
package mips_pkg;

  typedef struct packed {
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam logic [1:0] REGDST_RT    = 2'b00;
  localparam logic [1:0] REGDST_RD    = 2'b01;
  localparam logic [1:0] REGDST_RA    = 2'b10;

  localparam logic [1:0] MEMTOREG_ALU = 2'b00;
  localparam logic [1:0] MEMTOREG_MEM = 2'b01;
  localparam logic [1:0] MEMTOREG_PC4 = 2'b10;

  localparam int REG_RA = 31;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use hazard check between EX and ID
module hazard_detect #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  ex_valid,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_alu_src,
  input  logic                  id_mem_write,
  output logic                  load_use
);

  logic uses_rt;

  // rt is a source operand for R-type/branch (alu_src=0) and for stores (store data)
  assign uses_rt  = !id_alu_src | id_mem_write;
  assign load_use = ex_valid & ex_mem_read & (ex_rt != '0) & id_valid &
                    ((ex_rt == id_rs) | (uses_rt & (ex_rt == id_rt)));

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use bubble insertion (option: ID_EX_BUBBLE_CNT_EN)
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
`ifdef ID_EX_BUBBLE_CNT_EN
  ,
  parameter int CNT_W      = 16
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid_i,
  input  logic [1:0]            id_reg_dst_i,
  input  logic                  id_branch_i,
  input  logic                  id_mem_read_i,
  input  logic                  id_mem_write_i,
  input  logic                  id_alu_src_i,
  input  logic                  id_reg_write_i,
  input  logic [1:0]            id_mem_to_reg_i,
  input  logic [1:0]            id_alu_op_i,
  input  logic [REG_ADDR_W-1:0] id_rs_i,
  input  logic [REG_ADDR_W-1:0] id_rt_i,
  input  logic [REG_ADDR_W-1:0] id_rd_i,
  input  logic [DATA_W-1:0]     id_rdata1_i,
  input  logic [DATA_W-1:0]     id_rdata2_i,
  input  logic [DATA_W-1:0]     id_imm_i,
  input  logic [DATA_W-1:0]     id_pc4_i,
  input  logic [5:0]            id_funct_i,
  input  logic                  flush_i,
  input  logic                  ex_hold_i,
  output logic                  ex_valid_o,
  output logic [1:0]            ex_reg_dst_o,
  output logic                  ex_branch_o,
  output logic                  ex_mem_read_o,
  output logic                  ex_mem_write_o,
  output logic                  ex_alu_src_o,
  output logic                  ex_reg_write_o,
  output logic [1:0]            ex_mem_to_reg_o,
  output logic [1:0]            ex_alu_op_o,
  output logic [REG_ADDR_W-1:0] ex_rs_o,
  output logic [REG_ADDR_W-1:0] ex_rt_o,
  output logic [REG_ADDR_W-1:0] ex_rd_o,
  output logic [DATA_W-1:0]     ex_rdata1_o,
  output logic [DATA_W-1:0]     ex_rdata2_o,
  output logic [DATA_W-1:0]     ex_imm_o,
  output logic [DATA_W-1:0]     ex_pc4_o,
  output logic [5:0]            ex_funct_o,
  output logic [REG_ADDR_W-1:0] ex_wreg_o,
`ifdef ID_EX_BUBBLE_CNT_EN
  output logic [CNT_W-1:0]      bubble_cnt_o,
`endif
  output logic                  stall_o
);

  ctrl_t                  id_ctrl;
  ctrl_t                  ex_ctrl;
  logic                   load_use;
  logic [REG_ADDR_W-1:0]  wreg_next;

  assign id_ctrl = '{branch:     id_branch_i,
                     mem_read:   id_mem_read_i,
                     mem_write:  id_mem_write_i,
                     alu_src:    id_alu_src_i,
                     reg_write:  id_reg_write_i,
                     reg_dst:    id_reg_dst_i,
                     mem_to_reg: id_mem_to_reg_i,
                     alu_op:     id_alu_op_i};

  hazard_detect #(.REG_ADDR_W(REG_ADDR_W)) u_hazard (
    .ex_valid     (ex_valid_o),
    .ex_mem_read  (ex_mem_read_o),
    .ex_rt        (ex_rt_o),
    .id_valid     (id_valid_i),
    .id_rs        (id_rs_i),
    .id_rt        (id_rt_i),
    .id_alu_src   (id_alu_src_i),
    .id_mem_write (id_mem_write_i),
    .load_use     (load_use)
  );

  assign stall_o = !flush_i & (ex_hold_i | load_use);

  // RegDst is a don't-care for non-writing instructions, so gate on reg_write
  always_comb begin
    wreg_next = '0;
    if (id_valid_i && id_reg_write_i) begin
      case (id_reg_dst_i)
        REGDST_RT: wreg_next = id_rt_i;
        REGDST_RD: wreg_next = id_rd_i;
        REGDST_RA: wreg_next = REG_ADDR_W'(REG_RA);
        default:   wreg_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_o  <= 1'b0;
      ex_ctrl     <= '0;
      ex_wreg_o   <= '0;
      ex_rs_o     <= '0;
      ex_rt_o     <= '0;
      ex_rd_o     <= '0;
      ex_rdata1_o <= '0;
      ex_rdata2_o <= '0;
      ex_imm_o    <= '0;
      ex_pc4_o    <= '0;
      ex_funct_o  <= '0;
    end else if (flush_i || !ex_hold_i) begin
      // data fields follow ID even on a bubble; only controls are squashed
      ex_rs_o     <= id_rs_i;
      ex_rt_o     <= id_rt_i;
      ex_rd_o     <= id_rd_i;
      ex_rdata1_o <= id_rdata1_i;
      ex_rdata2_o <= id_rdata2_i;
      ex_imm_o    <= id_imm_i;
      ex_pc4_o    <= id_pc4_i;
      ex_funct_o  <= id_funct_i;
      if (flush_i || load_use) begin
        ex_valid_o <= 1'b0;
        ex_ctrl    <= '0;
        ex_wreg_o  <= '0;
      end else begin
        ex_valid_o <= id_valid_i;
        ex_ctrl    <= id_valid_i ? id_ctrl : '0;
        ex_wreg_o  <= wreg_next;
      end
    end
  end

  assign ex_branch_o     = ex_ctrl.branch;
  assign ex_mem_read_o   = ex_ctrl.mem_read;
  assign ex_mem_write_o  = ex_ctrl.mem_write;
  assign ex_alu_src_o    = ex_ctrl.alu_src;
  assign ex_reg_write_o  = ex_ctrl.reg_write;
  assign ex_reg_dst_o    = ex_ctrl.reg_dst;
  assign ex_mem_to_reg_o = ex_ctrl.mem_to_reg;
  assign ex_alu_op_o     = ex_ctrl.alu_op;

`ifdef ID_EX_BUBBLE_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt_o <= '0;
    end else if (!flush_i && !ex_hold_i && load_use && (bubble_cnt_o != '1)) begin
      bubble_cnt_o <= bubble_cnt_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed self-checking bench for id_ex_stage
module tb_id_ex_stage;

  logic        clk, rst_n;
  logic        id_valid_i;
  logic [1:0]  id_reg_dst_i;
  logic        id_branch_i, id_mem_read_i, id_mem_write_i, id_alu_src_i, id_reg_write_i;
  logic [1:0]  id_mem_to_reg_i, id_alu_op_i;
  logic [4:0]  id_rs_i, id_rt_i, id_rd_i;
  logic [31:0] id_rdata1_i, id_rdata2_i, id_imm_i, id_pc4_i;
  logic [5:0]  id_funct_i;
  logic        flush_i, ex_hold_i;
  logic        ex_valid_o;
  logic [1:0]  ex_reg_dst_o;
  logic        ex_branch_o, ex_mem_read_o, ex_mem_write_o, ex_alu_src_o, ex_reg_write_o;
  logic [1:0]  ex_mem_to_reg_o, ex_alu_op_o;
  logic [4:0]  ex_rs_o, ex_rt_o, ex_rd_o, ex_wreg_o;
  logic [31:0] ex_rdata1_o, ex_rdata2_o, ex_imm_o, ex_pc4_o;
  logic [5:0]  ex_funct_o;
  logic        stall_o;
`ifdef ID_EX_BUBBLE_CNT_EN
  logic [15:0] bubble_cnt_o;
`endif

  int nchk;
  int nfail;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid_i), .id_reg_dst_i(id_reg_dst_i),
    .id_branch_i(id_branch_i), .id_mem_read_i(id_mem_read_i), .id_mem_write_i(id_mem_write_i),
    .id_alu_src_i(id_alu_src_i), .id_reg_write_i(id_reg_write_i), .id_mem_to_reg_i(id_mem_to_reg_i),
    .id_alu_op_i(id_alu_op_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_rd_i(id_rd_i),
    .id_rdata1_i(id_rdata1_i), .id_rdata2_i(id_rdata2_i), .id_imm_i(id_imm_i), .id_pc4_i(id_pc4_i),
    .id_funct_i(id_funct_i), .flush_i(flush_i), .ex_hold_i(ex_hold_i),
    .ex_valid_o(ex_valid_o), .ex_reg_dst_o(ex_reg_dst_o), .ex_branch_o(ex_branch_o),
    .ex_mem_read_o(ex_mem_read_o), .ex_mem_write_o(ex_mem_write_o), .ex_alu_src_o(ex_alu_src_o),
    .ex_reg_write_o(ex_reg_write_o), .ex_mem_to_reg_o(ex_mem_to_reg_o), .ex_alu_op_o(ex_alu_op_o),
    .ex_rs_o(ex_rs_o), .ex_rt_o(ex_rt_o), .ex_rd_o(ex_rd_o), .ex_rdata1_o(ex_rdata1_o),
    .ex_rdata2_o(ex_rdata2_o), .ex_imm_o(ex_imm_o), .ex_pc4_o(ex_pc4_o), .ex_funct_o(ex_funct_o),
    .ex_wreg_o(ex_wreg_o),
`ifdef ID_EX_BUBBLE_CNT_EN
    .bubble_cnt_o(bubble_cnt_o),
`endif
    .stall_o(stall_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] rdst, input logic br, input logic mr,
                       input logic mw, input logic asrc, input logic rw, input logic [1:0] m2r,
                       input logic [1:0] aop, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd);
    id_valid_i = v;    id_reg_dst_i = rdst; id_branch_i = br;  id_mem_read_i = mr;
    id_mem_write_i = mw; id_alu_src_i = asrc; id_reg_write_i = rw; id_mem_to_reg_i = m2r;
    id_alu_op_i = aop; id_rs_i = rs; id_rt_i = rt; id_rd_i = rd;
    id_rdata1_i = 32'h1000 + 32'(rs); id_rdata2_i = 32'h2000 + 32'(rt);
    id_imm_i = 32'h0000_0010; id_pc4_i = 32'h0000_0400; id_funct_i = 6'h20;
    #1;
  endtask

  task automatic drive_lw(input logic [4:0] rs, input logic [4:0] rt);
    drive(1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b01, 2'b00, rs, rt, 5'd0);
  endtask

  task automatic drive_add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    drive(1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b10, rs, rt, rd);
  endtask

  task automatic test_reset();
    rst_n = 1'b1; flush_i = 1'b0; ex_hold_i = 1'b0;
    drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 5'd0, 5'd0, 5'd0);
    #1 rst_n = 1'b0;
    #1;
    nchk++; if (ex_valid_o !== 1'b0) begin nfail++; $display("FAIL reset_valid: got %0d expected 0", ex_valid_o); end
    nchk++; if (ex_wreg_o !== 5'd0) begin nfail++; $display("FAIL reset_wreg: got %0d expected 0", ex_wreg_o); end
    nchk++; if (stall_o !== 1'b0) begin nfail++; $display("FAIL reset_stall: got %0d expected 0", stall_o); end
    nchk++; if (ex_pc4_o !== 32'd0) begin nfail++; $display("FAIL reset_pc4: got %0h expected 0", ex_pc4_o); end
    step(); step();
    @(negedge clk) rst_n = 1'b1;
    #1;
  endtask

  task automatic test_rtype_addi();
    drive_add(5'd2, 5'd3, 5'd9);
    step();
    nchk++; if (ex_wreg_o !== 5'd9) begin nfail++; $display("FAIL rtype_wreg: got %0d expected 9", ex_wreg_o); end
    nchk++; if (ex_alu_op_o !== 2'b10) begin nfail++; $display("FAIL rtype_aluop: got %0d expected 2", ex_alu_op_o); end
    nchk++; if (ex_valid_o !== 1'b1) begin nfail++; $display("FAIL rtype_valid: got %0d expected 1", ex_valid_o); end
    nchk++; if (ex_rdata1_o !== 32'h1002) begin nfail++; $display("FAIL rtype_rdata1: got %0h expected 1002", ex_rdata1_o); end
    drive(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 5'd2, 5'd4, 5'd0);
    step();
    nchk++; if (ex_wreg_o !== 5'd4) begin nfail++; $display("FAIL addi_wreg: got %0d expected 4", ex_wreg_o); end
    nchk++; if (ex_alu_op_o !== 2'b00) begin nfail++; $display("FAIL addi_aluop: got %0d expected 0", ex_alu_op_o); end
    nchk++; if (ex_alu_src_o !== 1'b1) begin nfail++; $display("FAIL addi_alusrc: got %0d expected 1", ex_alu_src_o); end
  endtask

  task automatic test_load_use();
    drive_lw(5'd1, 5'd5);
    step();
    drive_add(5'd5, 5'd7, 5'd6);
    nchk++; if (stall_o !== 1'b1) begin nfail++; $display("FAIL lu_stall: got %0d expected 1", stall_o); end
    step();
    nchk++; if (ex_valid_o !== 1'b0) begin nfail++; $display("FAIL lu_bubble_valid: got %0d expected 0", ex_valid_o); end
    nchk++; if (ex_reg_write_o !== 1'b0 || ex_mem_read_o !== 1'b0 || ex_alu_op_o !== 2'b00)
      begin nfail++; $display("FAIL lu_bubble_ctrl: got rw=%0d mr=%0d op=%0d expected 0", ex_reg_write_o, ex_mem_read_o, ex_alu_op_o); end
    nchk++; if (ex_wreg_o !== 5'd0) begin nfail++; $display("FAIL lu_bubble_wreg: got %0d expected 0", ex_wreg_o); end
    nchk++; if (ex_rs_o !== 5'd5) begin nfail++; $display("FAIL lu_bubble_data: got %0d expected 5", ex_rs_o); end
    nchk++; if (stall_o !== 1'b0) begin nfail++; $display("FAIL lu_stall_once: got %0d expected 0", stall_o); end
    step();
    nchk++; if (ex_valid_o !== 1'b1 || ex_wreg_o !== 5'd6)
      begin nfail++; $display("FAIL lu_add_captured: got v=%0d wreg=%0d expected v=1 wreg=6", ex_valid_o, ex_wreg_o); end
`ifdef ID_EX_BUBBLE_CNT_EN
    nchk++; if (bubble_cnt_o !== 16'd1) begin nfail++; $display("FAIL lu_cnt: got %0d expected 1", bubble_cnt_o); end
`endif
  endtask

  task automatic test_no_stall();
    drive_lw(5'd1, 5'd5);
    step();
    drive(1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 5'd2, 5'd5, 5'd0);
    nchk++; if (stall_o !== 1'b0) begin nfail++; $display("FAIL addi_rt_nostall: got %0d expected 0", stall_o); end
    step();
    nchk++; if (ex_valid_o !== 1'b1 || ex_wreg_o !== 5'd5)
      begin nfail++; $display("FAIL addi_rt_capture: got v=%0d wreg=%0d expected v=1 wreg=5", ex_valid_o, ex_wreg_o); end
    drive_lw(5'd1, 5'd0);
    step();
    drive_add(5'd0, 5'd0, 5'd8);
    nchk++; if (stall_o !== 1'b0) begin nfail++; $display("FAIL lw_r0_nostall: got %0d expected 0", stall_o); end
    step();
  endtask

  task automatic test_flush();
    drive_lw(5'd1, 5'd5);
    step();
    drive_add(5'd5, 5'd7, 5'd6);
    flush_i = 1'b1;
    #1;
    nchk++; if (stall_o !== 1'b0) begin nfail++; $display("FAIL flush_stall: got %0d expected 0", stall_o); end
    step();
    flush_i = 1'b0;
    nchk++; if (ex_valid_o !== 1'b0 || ex_wreg_o !== 5'd0 || ex_reg_write_o !== 1'b0)
      begin nfail++; $display("FAIL flush_bubble: got v=%0d wreg=%0d rw=%0d expected 0", ex_valid_o, ex_wreg_o, ex_reg_write_o); end
`ifdef ID_EX_BUBBLE_CNT_EN
    nchk++; if (bubble_cnt_o !== 16'd1) begin nfail++; $display("FAIL flush_cnt: got %0d expected 1", bubble_cnt_o); end
`endif
  endtask

  task automatic test_back_to_back();
    drive_lw(5'd1, 5'd5);
    step();
    drive_lw(5'd5, 5'd6);
    nchk++; if (stall_o !== 1'b1) begin nfail++; $display("FAIL b2b_stall1: got %0d expected 1", stall_o); end
    step();
    nchk++; if (stall_o !== 1'b0) begin nfail++; $display("FAIL b2b_release: got %0d expected 0", stall_o); end
    step();
    drive_add(5'd6, 5'd7, 5'd3);
    nchk++; if (stall_o !== 1'b1) begin nfail++; $display("FAIL b2b_stall2: got %0d expected 1", stall_o); end
    step();
    nchk++; if (ex_valid_o !== 1'b0) begin nfail++; $display("FAIL b2b_bubble: got %0d expected 0", ex_valid_o); end
`ifdef ID_EX_BUBBLE_CNT_EN
    nchk++; if (bubble_cnt_o !== 16'd3) begin nfail++; $display("FAIL b2b_cnt: got %0d expected 3", bubble_cnt_o); end
`endif
    step();
  endtask

  task automatic test_hold();
    drive(1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 5'd0, 5'd0, 5'd0);
    id_pc4_i = 32'h0000_0104;
    step();
    ex_hold_i = 1'b1;
    drive_add(5'd1, 5'd2, 5'd3);
    for (int i = 0; i < 3; i++) begin
      nchk++; if (stall_o !== 1'b1) begin nfail++; $display("FAIL hold_stall[%0d]: got %0d expected 1", i, stall_o); end
      step();
      nchk++; if (ex_wreg_o !== 5'd31 || ex_mem_to_reg_o !== 2'b10 || ex_pc4_o !== 32'h104)
        begin nfail++; $display("FAIL hold_frozen[%0d]: got wreg=%0d m2r=%0d pc4=%0h expected 31 2 104", i, ex_wreg_o, ex_mem_to_reg_o, ex_pc4_o); end
    end
    ex_hold_i = 1'b0;
    #1;
  endtask

  task automatic test_store_and_scrub();
    drive(1'b1, 2'bxx, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'bxx, 2'b00, 5'd4, 5'd5, 5'd0);
    step();
    nchk++; if (ex_wreg_o !== 5'd0 || ex_reg_write_o !== 1'b0)
      begin nfail++; $display("FAIL sw_wreg: got wreg=%0d rw=%0d expected 0 0", ex_wreg_o, ex_reg_write_o); end
    nchk++; if (ex_mem_write_o !== 1'b1) begin nfail++; $display("FAIL sw_memwrite: got %0d expected 1", ex_mem_write_o); end
    drive(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b10, 5'd1, 5'd2, 5'd3);
    step();
    nchk++; if (ex_wreg_o !== 5'd0) begin nfail++; $display("FAIL regdst11_wreg: got %0d expected 0", ex_wreg_o); end
    drive(1'b0, 2'b01, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 2'b11, 5'd1, 5'd2, 5'd3);
    step();
    nchk++; if (ex_valid_o !== 1'b0 || ex_branch_o !== 1'b0 || ex_mem_read_o !== 1'b0 || ex_alu_op_o !== 2'b00 || ex_wreg_o !== 5'd0)
      begin nfail++; $display("FAIL invalid_scrub: got v=%0d br=%0d mr=%0d op=%0d wreg=%0d expected 0", ex_valid_o, ex_branch_o, ex_mem_read_o, ex_alu_op_o, ex_wreg_o); end
    nchk++; if (ex_rd_o !== 5'd3) begin nfail++; $display("FAIL invalid_data: got %0d expected 3", ex_rd_o); end
  endtask

  task automatic test_async_reset();
    drive_add(5'd2, 5'd3, 5'd9);
    step();
    #2 rst_n = 1'b0;
    #1;
    nchk++; if (ex_valid_o !== 1'b0 || ex_wreg_o !== 5'd0 || ex_reg_write_o !== 1'b0 || ex_rdata1_o !== 32'd0)
      begin nfail++; $display("FAIL async_reset: got v=%0d wreg=%0d rw=%0d rd1=%0h expected 0", ex_valid_o, ex_wreg_o, ex_reg_write_o, ex_rdata1_o); end
`ifdef ID_EX_BUBBLE_CNT_EN
    nchk++; if (bubble_cnt_o !== 16'd0) begin nfail++; $display("FAIL async_reset_cnt: got %0d expected 0", bubble_cnt_o); end
`endif
    @(negedge clk) rst_n = 1'b1;
  endtask

  initial begin
    nchk = 0;
    nfail = 0;
    test_reset();
    test_rtype_addi();
    test_load_use();
    test_no_stall();
    test_flush();
    test_back_to_back();
    test_hold();
    test_store_and_scrub();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
